// File: rtl/prbs8_checker.sv
// prbs8_checker: receive-side checker for the 8-bit LFSR byte stream
//   q <= {q[4]^q[3]^q[2]^q[0], q[7:1]}.
// The checker seeds itself from the incoming bytes while hunting. Once it has seen LOCK_CNT
// consecutive correct predictions, it locks and then counts every mismatching byte.
// Optional build macro PRBS_SEG_DISP_EN adds two 7-segment digits (seg2/seg1) that show
// err_cnt[7:0] in hex.
module prbs8_checker #(
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_SEG_DISP_EN
    ,
    output logic [7:0]       seg2,
    output logic [7:0]       seg1
`endif
);

    typedef enum logic {StHunt, StLocked} state_e;

    // The seed beat sets run to 1, so the LOCK_CNT-th correct prediction arrives with
    // run == LOCK_CNT before its increment.
    localparam logic [3:0] LockRun = 4'(LOCK_CNT);
    localparam logic [3:0] LossRun = 4'(LOSS_CNT - 1);

    state_e     state;
    logic [7:0] pred;
    logic [3:0] run;
    logic       bad_beat;

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    // A mismatching byte accepted while locked
    always_comb begin
        bad_beat = in_valid && (state == StLocked) && (in_data != pred);
    end

    // Sync FSM: hunt/reseed, flywheel prediction when locked, registered flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StHunt;
            pred      <= 8'h00;
            run       <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    StHunt: begin
                        if (run == 4'd0 || in_data != pred) begin
                            // Reseed; the all-zero lock-up byte is never a valid seed
                            if (in_data != 8'h00) begin
                                pred <= step(in_data);
                                run  <= 4'd1;
                            end else begin
                                run  <= 4'd0;
                            end
                        end else if (run == LockRun) begin
                            state  <= StLocked;
                            locked <= 1'b1;
                            run    <= 4'd0;
                            pred   <= step(in_data);
                        end else begin
                            run  <= run + 4'd1;
                            pred <= step(in_data);
                        end
                    end
                    StLocked: begin
                        // Flywheel: bad data never disturbs the prediction
                        pred <= step(pred);
                        if (in_data == pred) begin
                            run <= 4'd0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (run == LossRun) begin
                                state  <= StHunt;
                                locked <= 1'b0;
                                run    <= 4'd0;
                                pred   <= 8'h00;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state <= StHunt;
                    end
                endcase
            end
        end
    end

    // Saturating error counter; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (bad_beat && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

`ifdef PRBS_SEG_DISP_EN
    logic [7:0] cnt_byte;

    // Low byte of the count, zero-padded when the counter is narrower than a byte
    if (CNT_W >= 8) begin : g_byte_wide
        assign cnt_byte = err_cnt[7:0];
    end else begin : g_byte_narrow
        assign cnt_byte = {(8 - CNT_W)'(0), err_cnt};
    end

    // Active-low {a,b,c,d,e,f,g,dp}, decimal point always off
    function automatic logic [7:0] hex7(input logic [3:0] v);
        unique case (v)
            4'h0: return 8'h03;
            4'h1: return 8'h9F;
            4'h2: return 8'h25;
            4'h3: return 8'h0D;
            4'h4: return 8'h99;
            4'h5: return 8'h49;
            4'h6: return 8'h41;
            4'h7: return 8'h1F;
            4'h8: return 8'h01;
            4'h9: return 8'h09;
            4'hA: return 8'h11;
            4'hB: return 8'hC1;
            4'hC: return 8'h63;
            4'hD: return 8'h85;
            4'hE: return 8'h61;
            default: return 8'h71;
        endcase
    endfunction

    // Display digits lag err_cnt by one cycle; blank in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg2 <= 8'hFF;
            seg1 <= 8'hFF;
        end else begin
            seg2 <= hex7(cnt_byte[7:4]);
            seg1 <= hex7(cnt_byte[3:0]);
        end
    end
`endif

endmodule
